// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential restoring divider.
//   state_e : controller states (IDLE, CALC, DONE)
//   DIV_DW  : default dividend/quotient width
//   DIV_VW  : default divisor/remainder width
package div_pkg;

  localparam int unsigned DIV_DW = 8;
  localparam int unsigned DIV_VW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
//   rem_in   [VW-1:0] : partial remainder entering the step
//   dvd_bit           : next dividend bit (MSB first)
//   divisor  [VW-1:0] : divisor
//   rem_out  [VW-1:0] : partial remainder leaving the step
//   q_bit             : quotient bit produced by the step
module div_step
  import div_pkg::*;
#(
  parameter int unsigned VW = DIV_VW
) (
  input  logic [VW-1:0] rem_in,
  input  logic          dvd_bit,
  input  logic [VW-1:0] divisor,
  output logic [VW-1:0] rem_out,
  output logic          q_bit
);

  logic [VW:0] trial;

  always_comb begin
    trial   = {rem_in, dvd_bit};
    rem_out = trial[VW-1:0];
    q_bit   = 1'b0;
    if (divisor == '0) begin
      // Division by zero saturates: remainder pinned to all ones, every
      // quotient bit set, so the full run yields all-ones for both.
      rem_out = '1;
      q_bit   = 1'b1;
    end else if (trial >= {1'b0, divisor}) begin
      // rem_in < divisor keeps the difference below divisor, so the
      // modulo-2^VW subtraction on the low bits is exact.
      rem_out = trial[VW-1:0] - divisor;
      q_bit   = 1'b1;
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq -- sequential unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n         : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  : operand handshake (accepted only in IDLE)
//   dividend [DW-1:0]  : unsigned dividend
//   divisor  [VW-1:0]  : unsigned divisor
//   out_valid/out_ready: result handshake (result held until accepted)
//   quotient [DW-1:0]  : unsigned quotient
//   remainder[VW-1:0]  : unsigned remainder
//   div0               : only with DIV_SEQ_DIV0_EN defined; flags a
//                        divide-by-zero result produced in a single cycle
// Macro DIV_SEQ_DIV0_EN: enables the fast divide-by-zero path and div0 port.
// Without it a zero divisor runs the normal DW steps and saturates to all ones.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned DW = DIV_DW,
  parameter int unsigned VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef DIV_SEQ_DIV0_EN
  ,
  output logic          div0
`endif
);

  localparam int unsigned CW = $clog2(DW + 1);

  state_e        state, state_nxt;
  logic [DW-1:0] work;      // dividend bits shift out at the top, quotient bits in at the bottom
  logic [VW-1:0] dvs;
  logic [VW-1:0] rem;
  logic [CW-1:0] cnt;
  logic [VW-1:0] step_rem;
  logic          step_q;
  logic          accept;
  logic          last;
  logic          zero_fast;

  div_step #(.VW(VW)) u_step (
    .rem_in  (rem),
    .dvd_bit (work[DW-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign accept = (state == IDLE) && in_valid;
  // cnt reaches DW one cycle after the final step; that cycle publishes the result.
  assign last   = (cnt == CW'(DW));

`ifdef DIV_SEQ_DIV0_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = zero_fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_SEQ_DIV0_EN
      div0      <= 1'b0;
`endif
    end else if (accept) begin
      work <= dividend;
      dvs  <= divisor;
      rem  <= '0;
      cnt  <= '0;
`ifdef DIV_SEQ_DIV0_EN
      if (zero_fast) begin
        quotient  <= '1;
        remainder <= '1;
        div0      <= 1'b1;
      end
`endif
    end else if (state == CALC) begin
      if (!last) begin
        work <= (work << 1) | DW'(step_q);
        rem  <= step_rem;
        cnt  <= cnt + CW'(1);
      end else begin
        quotient  <= work;
        remainder <= rem;
`ifdef DIV_SEQ_DIV0_EN
        div0      <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;
`ifdef DIV_SEQ_DIV0_EN
  localparam int DIV0_LAT = 0;
`else
  localparam int DIV0_LAT = 9;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
`ifdef DIV_SEQ_DIV0_EN
  logic          div0;
`endif

  div_seq #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_SEQ_DIV0_EN
    ,
    .div0      (div0)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    int            lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic launch(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    chk("in_ready_before_launch", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, output int cyc);
    bit busy_ok;
    busy_ok = 1'b1;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_in_ready_low_while_busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er, input int elat,
                        input bit div0_exp);
    int cyc;
    launch(a, b);
    wait_valid(nm, cyc);
    chk({nm, "_latency"}, 32'(cyc), 32'(elat));
    chk({nm, "_quotient"}, 32'(quotient), 32'(eq));
    chk({nm, "_remainder"}, 32'(remainder), 32'(er));
    chk({nm, "_in_ready_done"}, 32'(in_ready), 32'd0);
`ifdef DIV_SEQ_DIV0_EN
    chk({nm, "_div0"}, 32'(div0), 32'(div0_exp));
`else
    if (div0_exp) ;
`endif
    @(posedge clk);
    #1;
    chk({nm, "_back_to_idle"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{8'd143, 4'd11, 8'd13,  4'd0,  9};
    vecs[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  9};
    vecs[2] = '{8'd7,   4'd15, 8'd0,   4'd7,  9};
    vecs[3] = '{8'd0,   4'd5,  8'd0,   4'd0,  9};
    vecs[4] = '{8'd255, 4'd15, 8'd17,  4'd0,  9};
    vecs[5] = '{8'd254, 4'd15, 8'd16,  4'd14, 9};
    vecs[6] = '{8'd100, 4'd7,  8'd14,  4'd2,  9};
    vecs[7] = '{8'd1,   4'd1,  8'd1,   4'd0,  9};
    vecs[8] = '{8'd15,  4'd4,  8'd3,   4'd3,  9};
    vecs[9] = '{8'd57,  4'd0,  8'd255, 4'd15, DIV0_LAT};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
`ifdef DIV_SEQ_DIV0_EN
    chk("reset_div0", 32'(div0), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             vecs[i].lat, (vecs[i].b == 0) && (DIV0_LAT == 0));
    end

    // Every product A*B divided by B returns A with zero remainder
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        launch(8'(a * b), 4'(b));
        wait_valid("prod", cyc);
        chk($sformatf("prod_%0dx%0d_q", a, b), 32'(quotient), 32'(a));
        chk($sformatf("prod_%0dx%0d_r", a, b), 32'(remainder), 32'd0);
        chk($sformatf("prod_%0dx%0d_identity", a, b),
            32'(quotient) * 32'(b) + 32'(remainder), 32'(a * b));
        @(posedge clk);
        #1;
      end
    end

    // Backpressure with a competing operand offered during CALC/DONE
    out_ready = 1'b0;
    launch(8'd200, 4'd9);
    in_valid = 1'b1;
    dividend = 8'd77;
    divisor  = 4'd5;
    wait_valid("bp", cyc);
    chk("bp_latency", 32'(cyc), 32'd9);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_quotient", 32'(quotient), 32'd22);
      chk("bp_hold_remainder", 32'(remainder), 32'd2);
      chk("bp_hold_out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_idle", 32'({in_ready, out_valid}), 32'b10);

    // Reset during step 4 of 100/3
    launch(8'd100, 4'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_calc_out_valid", 32'(out_valid), 32'd0);
    chk("rst_calc_in_ready", 32'(in_ready), 32'd1);
    chk("rst_calc_quotient", 32'(quotient), 32'd0);
    chk("rst_calc_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 8'd100, 4'd3, 8'd33, 4'd1, 9, 1'b0);

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    launch(8'd143, 4'd11);
    wait_valid("rst_done", cyc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done_quotient", 32'(quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_done_idle", 32'({in_ready, out_valid}), 32'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter DW, default 8, dividend and quotient width.
REQ-002 Parameter VW, default 4, divisor and remainder width.
REQ-003 clk  input  1  clock, posedge; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  dividend/divisor offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 dividend  input  DW  unsigned dividend (e.g. a product).
REQ-008 divisor  input  VW  unsigned divisor.
REQ-009 out_valid  output  1  quotient/remainder valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 quotient  output  DW  unsigned quotient.
REQ-012 remainder  output  VW  unsigned remainder.

Function
REQ-013 FSM states: IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1; on in_valid, latch dividend/divisor, clear partial remainder and step counter, go to CALC.
REQ-015 CALC: in_ready=0; one restoring step per cycle, MSB first; DW steps; after step DW-1 go to DONE.
REQ-016 Restoring step: partial remainder (VW+1 bits) = {rem, next dividend bit}; if >= divisor, subtract and shift in quotient bit 1, else keep and shift in 0.
REQ-017 Latency: handshake at edge k -> out_valid=1 after edge k+DW+1 (default: 9 cycles).
REQ-018 DONE: out_valid=1; quotient/remainder stable; in_ready=0; on out_ready, go to IDLE.
REQ-019 Result hold: outputs stay unchanged while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 No back-to-back overlap: a new operand is accepted only in IDLE; in_valid during CALC/DONE is ignored.
REQ-021 Divisor 0 without the macro: normal DW-step run; quotient = all ones, remainder = all ones.
REQ-022 Results satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.

Reset
REQ-023 rst_n low, at any time including mid-CALC or in DONE: state=IDLE immediately; in_ready=1 after release; out_valid=0; quotient=0; remainder=0; counter=0.
REQ-024 An operation interrupted by reset produces no result; the first accepted operand after release starts a clean computation.

Configuration
REQ-025 Macro DIV_SEQ_DIV0_EN defined: extra output port div0 (1 bit); divisor 0 goes IDLE->DONE in one cycle with quotient all ones, remainder all ones, div0=1; div0=0 for all other results; div0 resets to 0.
REQ-026 DIV_SEQ_DIV0_EN undefined: no div0 port; divisor 0 behaves per REQ-021.

Structure
REQ-027 Package div_pkg holds the state enum (IDLE/CALC/DONE) and the default DW/VW constants.
REQ-028 Sub-module div_step: combinational single restoring step (inputs: partial remainder, dividend bit, divisor; outputs: new remainder, quotient bit), instantiated once in div_seq.

Verification
REQ-029 143/11 -> after 9 cycles quotient=13, remainder=0.
REQ-030 255/1 -> quotient=255, remainder=0; 7/15 -> quotient=0, remainder=7.
REQ-031 Exhaustive: all products A*B (A,B 1..15) divided by B -> quotient=A, remainder=0; every result satisfies REQ-022.
REQ-032 Backpressure: 200/9 with out_ready=0 for 5 cycles -> quotient=22, remainder=2 held; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-033 Reset mid-CALC (step 4 of 100/3) -> out_valid=0, in_ready=1; next 100/3 -> quotient=33, remainder=1.
REQ-034 Divisor 0 (dividend 57): with macro, div0=1 after 1 cycle, quotient=255, remainder=15; without macro, same values after 9 cycles.
